dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated single-port data memory responder
//
// Accepts one load/store request at a time from a CPU-side initiator, holds it
// for WAIT_CYCLES wait states, executes it against a 16-bit word array and
// returns a one-cycle ack with an err flag for faulting accesses.
//
// Ports:
//   clock    in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset
//   req      in   1   request valid, sampled only in IDLE
//   we       in   1   1 = store, 0 = load
//   addr     in  16   byte address, word index = addr[11:2]
//   wdata    in  16   store data
//   rdata    out 16   registered load data, held until the next good load
//   ack      out  1   one-cycle completion strobe
//   err      out  1   access fault, qualified by ack
//   busy     out  1   high whenever not in IDLE

module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;

    logic [15:0] mem_q [DEPTH];

    // Operands of the access that executes on this edge. With zero wait
    // states the access runs on the accept edge itself, so the live inputs
    // are used; otherwise the captured copies are.
    logic        acc_go;
    logic        acc_we;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic [9:0]  acc_idx;
    logic        acc_fault;

    always_comb begin
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_go    = req && (WAIT_INIT == 4'd0);
        end else if (state_q == S_WAIT) begin
            acc_go = (cnt_q == 4'd1);
        end
    end

    assign acc_idx   = acc_addr[11:2];
    assign acc_fault = (acc_addr[1:0] != 2'b00)
                    || (acc_addr[15:12] != 4'h0)
                    || (32'(acc_idx) >= DEPTH);

    // Storage is never reset. The reset_n term stops a zero-wait request
    // presented during reset from writing while the FSM is held in IDLE.
    always_ff @(posedge clock) begin
        if (reset_n && acc_go && acc_we && !acc_fault) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= WAIT_INIT;
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Execution edge: enter RESP and register the response.
            if (acc_go) begin
                state_q <= S_RESP;
                busy_q  <= 1'b1;
                ack_q   <= 1'b1;
                err_q   <= acc_fault;
                if (!acc_we && !acc_fault) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder

module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [15:0] addr_s  [2];
    logic [15:0] wdata_s [2];
    logic [15:0] rdata_s [2];
    logic        ack_s   [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    // index 0: zero wait states, index 1: two wait states
    int unsigned wait_c [2] = '{0, 2};

    logic [15:0] mem_m   [2][1024];
    logic [15:0] rdata_m [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    dmem_responder #(.WAIT_CYCLES(0), .DEPTH(1024)) u_dut_w0 (
        .clock  (clock),
        .reset_n(reset_n),
        .req    (req_s[0]),
        .we     (we_s[0]),
        .addr   (addr_s[0]),
        .wdata  (wdata_s[0]),
        .rdata  (rdata_s[0]),
        .ack    (ack_s[0]),
        .err    (err_s[0]),
        .busy   (busy_s[0])
    );

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH(1024)) u_dut_w2 (
        .clock  (clock),
        .reset_n(reset_n),
        .req    (req_s[1]),
        .we     (we_s[1]),
        .addr   (addr_s[1]),
        .wdata  (wdata_s[1]),
        .rdata  (rdata_s[1]),
        .ack    (ack_s[1]),
        .err    (err_s[1]),
        .busy   (busy_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit is_fault(input logic [15:0] a);
        return (a % 4 != 0) || (a >= 16'h1000);
    endfunction

    // One complete request on instance s; hold keeps req high one extra cycle.
    task automatic do_access(input int s, input bit w, input logic [15:0] a,
                             input logic [15:0] d, input bit hold);
        int    n;
        string p;
        p = $sformatf("w%0d", wait_c[s]);
        @(negedge clock);
        chk({p, "_busy_before"}, 32'(busy_s[s]), 0);
        req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; wdata_s[s] = d;
        @(posedge clock); #1;
        if (!hold) req_s[s] = 1'b0;
        we_s[s]    = 1'($urandom_range(1, 0));
        addr_s[s]  = 16'($urandom);
        wdata_s[s] = 16'($urandom);
        if (!is_fault(a)) begin
            if (w) mem_m[s][a >> 2] = d;
            else   rdata_m[s] = mem_m[s][a >> 2];
        end
        chk({p, "_busy_after_accept"}, 32'(busy_s[s]), 1);
        n = 1;
        while (!ack_s[s] && n < 20) begin
            @(posedge clock); #1;
            req_s[s] = 1'b0;
            n++;
        end
        chk({p, "_ack_latency"}, 32'(n), wait_c[s] + 1);
        chk({p, "_err"}, 32'(err_s[s]), 32'(is_fault(a)));
        chk({p, "_rdata"}, 32'(rdata_s[s]), 32'(rdata_m[s]));
        @(posedge clock); #1;
        req_s[s] = 1'b0;
        chk({p, "_ack_one_cycle"}, 32'(ack_s[s]), 0);
        chk({p, "_busy_idle"}, 32'(busy_s[s]), 0);
    endtask

    // req held high through ack: exactly two acks, at the expected cycles.
    task automatic b2b(input int s, input logic [15:0] a);
        int acks, first, second, w;
        string p;
        p = $sformatf("w%0d", wait_c[s]);
        w = int'(wait_c[s]);
        acks = 0; first = -1; second = -1;
        @(negedge clock);
        req_s[s] = 1'b1; we_s[s] = 1'b0; addr_s[s] = a;
        rdata_m[s] = mem_m[s][a >> 2];
        @(posedge clock); #1;
        for (int c = 1; c <= 2 * w + 6; c++) begin
            if (c == w + 3) req_s[s] = 1'b0;
            if (ack_s[s]) begin
                acks++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(posedge clock); #1;
        end
        chk({p, "_b2b_ack_count"}, 32'(acks), 2);
        chk({p, "_b2b_first_ack"}, 32'(first), 32'(w + 1));
        chk({p, "_b2b_second_ack"}, 32'(second), 32'(2 * w + 3));
        chk({p, "_b2b_rdata"}, 32'(rdata_s[s]), 32'(rdata_m[s]));
    endtask

    task automatic reset_in_wait();
        int acks;
        @(negedge clock);
        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 16'h0008; wdata_s[1] = 16'hBEEF;
        @(posedge clock); #1;
        req_s[1] = 1'b0;
        @(negedge clock);
        chk("rst_busy_in_wait", 32'(busy_s[1]), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy_s[1]), 0);
        chk("rst_async_ack", 32'(ack_s[1]), 0);
        chk("rst_async_rdata", 32'(rdata_s[1]), 0);
        chk("rst_async_rdata_w0", 32'(rdata_s[0]), 0);
        rdata_m[0] = 16'h0000;
        rdata_m[1] = 16'h0000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (ack_s[1]) acks++;
        end
        chk("rst_no_ack", 32'(acks), 0);
        do_access(1, 1'b0, 16'h0008, 16'h0000, 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = 16'h0; wdata_s[s] = 16'h0;
            rdata_m[s] = 16'h0000;
        end

        // Requests presented while in reset must not be accepted.
        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b1; we_s[s] = 1'b1;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_busy_%0d", s), 32'(busy_s[s]), 0);
            chk($sformatf("reset_ack_%0d", s), 32'(ack_s[s]), 0);
            chk($sformatf("reset_err_%0d", s), 32'(err_s[s]), 0);
            chk($sformatf("reset_rdata_%0d", s), 32'(rdata_s[s]), 0);
        end
        @(negedge clock);
        for (int s = 0; s < 2; s++) req_s[s] = 1'b0;
        reset_n = 1'b1;

        // Give every word the random traffic touches a known value.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                do_access(s, 1'b1, 16'(i * 4), 16'($urandom), 1'b0);

        // Directed scenarios.
        do_access(1, 1'b1, 16'h0004, 16'h0007, 1'b0);
        do_access(1, 1'b0, 16'h0004, 16'h0000, 1'b0);
        do_access(0, 1'b1, 16'h0000, 16'h0005, 1'b0);
        do_access(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int s = 0; s < 2; s++) begin
            do_access(s, 1'b0, 16'h0006, 16'h0000, 1'b0);
            do_access(s, 1'b1, 16'h1000, 16'hDEAD, 1'b0);
            do_access(s, 1'b0, 16'h0000, 16'h0000, 1'b0);
            do_access(s, 1'b0, 16'h0008, 16'h0000, 1'b1);
            b2b(s, 16'h000C);
        end
        reset_in_wait();

        // Random traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            int          s;
            int          kind;
            logic [15:0] a;
            s    = it % 2;
            kind = int'($urandom_range(3, 0));
            case (kind)
                2:       a = 16'($urandom_range(31, 0) * 4 + $urandom_range(3, 1));
                3:       a = 16'($urandom_range(16'hFFFF, 16'h1000));
                default: a = 16'($urandom_range(31, 0) * 4);
            endcase
            do_access(s, 1'($urandom_range(1, 0)), a, 16'($urandom),
                      1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
